// File: rtl/md_pkg.sv
// Shared types and constants for the multiply/divide unit.
// Op encodings, controller states and the divide-by-zero quotient.
package md_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } md_state_e;

  localparam int MD_MAX_W = 64;

  // Quotient reported on divide by zero; sliced to WIDTH.
  localparam logic [MD_MAX_W-1:0] DIV0_LO = '1;

endpackage

// File: rtl/md_datapath.sv
// Shared shift-add multiply / restoring divide datapath with sign fix.
// Ports: i_load/i_step/i_fix strobes, i_dz, i_op, i_src1/2 -> o_hi/o_lo.
module md_datapath
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic             i_step,
  input  logic             i_fix,
  input  logic             i_dz,
  input  md_op_e           i_op,
  input  logic [WIDTH-1:0] i_src1,
  input  logic [WIDTH-1:0] i_src2,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int W = WIDTH;

  // mul: {partial hi, multiplier lo}; div: {rem, quo}
  logic [2*W-1:0] r_acc;
  // multiplicand or divisor magnitude
  logic [W-1:0]   r_b;
  logic           r_div;
  logic           r_dz;
  logic           r_neg_q;
  logic           r_neg_r;

  logic           w_sgn;
  logic           w_div_in;
  logic           w_s1;
  logic           w_s2;
  logic [W-1:0]   w_m1;
  logic [W-1:0]   w_m2;
  logic [W:0]     w_a;
  logic [W:0]     w_b;
  logic [W:0]     w_sum;
  logic [2*W-1:0] w_prod_n;
  logic [W-1:0]   w_q_n;
  logic [W-1:0]   w_r_n;

  always_comb begin
    w_sgn    = (i_op == MD_MULT) || (i_op == MD_DIV);
    w_div_in = (i_op == MD_DIV) || (i_op == MD_DIVU);
    w_s1     = w_sgn & i_src1[W-1];
    w_s2     = w_sgn & i_src2[W-1];
    w_m1     = w_s1 ? -i_src1 : i_src1;
    w_m2     = w_s2 ? -i_src2 : i_src2;
  end

  // One W+1 adder: add for multiply, subtract
  // (a + ~b + 1) for divide; bit W is the borrow.
  always_comb begin
    if (r_div) begin
      w_a = r_acc[2*W-1:W-1];
      w_b = ~{1'b0, r_b};
    end else begin
      w_a = {1'b0, r_acc[2*W-1:W]};
      w_b = r_acc[0] ? {1'b0, r_b} : '0;
    end
    w_sum = w_a + w_b + {{W{1'b0}}, r_div};
  end

  always_comb begin
    w_prod_n = -r_acc;
    w_q_n    = -r_acc[W-1:0];
    w_r_n    = -r_acc[2*W-1:W];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc   <= '0;
      r_b     <= '0;
      r_div   <= 1'b0;
      r_dz    <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      o_hi    <= '0;
      o_lo    <= '0;
    end else begin
      unique case (1'b1)
        i_load: begin
          r_div   <= w_div_in & ~i_dz;
          r_dz    <= i_dz;
          r_neg_q <= w_s1 ^ w_s2;
          r_neg_r <= w_s1;
          if (i_dz) begin
            // raw dividend kept for hi on /0
            r_acc <= {i_src1, DIV0_LO[W-1:0]};
          end else if (w_div_in) begin
            r_acc <= {{W{1'b0}}, w_m1};
            r_b   <= w_m2;
          end else begin
            r_acc <= {{W{1'b0}}, w_m2};
            r_b   <= w_m1;
          end
        end
        i_step: begin
          if (!r_div)
            r_acc <= {w_sum, r_acc[W-1:1]};
          else if (w_sum[W])
            r_acc <= {r_acc[2*W-2:0], 1'b0};
          else
            r_acc <= {w_sum[W-1:0],
                      r_acc[W-2:0], 1'b1};
        end
        default: ;
      endcase
      if (i_fix) begin
        unique case (1'b1)
          r_dz: begin
            o_hi <= r_acc[2*W-1:W];
            o_lo <= r_acc[W-1:0];
          end
          r_div: begin
            o_hi <= r_neg_r ? w_r_n
                            : r_acc[2*W-1:W];
            o_lo <= r_neg_q ? w_q_n
                            : r_acc[W-1:0];
          end
          default: begin
            {o_hi, o_lo} <= r_neg_q ? w_prod_n
                                    : r_acc;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/md_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU unit: FSM controller over md_datapath.
// Ports: start_i/op_i/src1_i/src2_i in; busy_o, done_o, div_by_zero_o, hi_o/lo_o out.
module md_sequencer
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_by_zero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  md_state_e     r_state;
  logic [CW-1:0] r_cnt;
  logic          r_dz;

  logic          w_load;
  logic          w_step;
  logic          w_fix;
  logic          w_dz;

  always_comb begin
    w_load = (r_state == IDLE) & start_i;
    w_step = (r_state == CALC);
    w_fix  = (r_state == FIX);
    w_dz   = op_i[1] & (src2_i == '0);
    busy_o = (r_state != IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_dz          <= 1'b0;
      done_o        <= 1'b0;
      div_by_zero_o <= 1'b0;
    end else begin
      done_o        <= 1'b0;
      div_by_zero_o <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start_i) begin
            r_dz    <= w_dz;
            r_cnt   <= '0;
            r_state <= w_dz ? FIX : CALC;
          end
        end
        CALC: begin
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(WIDTH - 1))
            r_state <= FIX;
        end
        FIX: begin
          done_o        <= 1'b1;
          div_by_zero_o <= r_dz;
          r_state       <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  md_datapath #(
    .WIDTH (WIDTH)
  ) u_dp (
    .i_clk   (clk_i),
    .i_rst_n (rst_i),
    .i_load  (w_load),
    .i_step  (w_step),
    .i_fix   (w_fix),
    .i_dz    (w_dz),
    .i_op    (md_op_e'(op_i)),
    .i_src1  (src1_i),
    .i_src2  (src2_i),
    .o_hi    (hi_o),
    .o_lo    (lo_o)
  );

endmodule

// File: tb/tb_md_sequencer.sv
// Directed + random bench for md_sequencer.
// Scoreboard queue of {dz, hi, lo}, checked on each done_o.
module tb_md_sequencer;

  logic        clk;
  logic        rst_i;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] src1_i;
  logic [31:0] src2_i;
  logic        busy_o;
  logic        done_o;
  logic        div_by_zero_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int checks = 0;
  int errors = 0;
  logic [64:0] sb[$];
  time t0;

  md_sequencer #(.WIDTH(32)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .op_i          (op_i),
    .src1_i        (src1_i),
    .src2_i        (src2_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .div_by_zero_o (div_by_zero_o),
    .hi_o          (hi_o),
    .lo_o          (lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [64:0] ref_md(
    input logic [1:0] op,
    input logic [31:0] a,
    input logic [31:0] b);
    longint sa, sb2, ua, ub, q, r;
    logic [63:0] v, qv, rv;
    sa  = {{32{a[31]}}, a};
    sb2 = {{32{b[31]}}, b};
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    v   = '0;
    if (op[1] && b == 32'd0)
      return {1'b1, a, 32'hFFFF_FFFF};
    case (op)
      2'b00: v = sa * sb2;
      2'b01: v = ua * ub;
      2'b10: begin
        q = sa / sb2; r = sa % sb2;
        qv = q; rv = r;
        v = {rv[31:0], qv[31:0]};
      end
      default: begin
        q = ua / ub; r = ua % ub;
        qv = q; rv = r;
        v = {rv[31:0], qv[31:0]};
      end
    endcase
    return {1'b0, v};
  endfunction

  // Drive a request; leaves time at accept edge + 1.
  task automatic start_op(input logic [1:0] op,
                          input logic [31:0] a,
                          input logic [31:0] b,
                          input logic [64:0] exp,
                          input bit push);
    start_i = 1'b1;
    op_i    = op;
    src1_i  = a;
    src2_i  = b;
    @(posedge clk);
    t0 = $time;
    #1;
    start_i = 1'b0;
    src1_i  = $urandom;
    src2_i  = $urandom;
    if (push) sb.push_back(exp);
    chk("accept_busy", 64'(busy_o), 64'd1);
    chk("accept_done_low", 64'(done_o), 64'd0);
  endtask

  task automatic wait_done(input string tag,
                           input int exp_lat);
    logic [31:0] h0, l0;
    logic [64:0] e;
    bit found, held, hold;
    int lat;
    h0 = hi_o; l0 = lo_o;
    found = 0; held = 1; hold = 1; lat = -1;
    for (int i = 0; i < 200; i++) begin
      if (done_o) begin
        found = 1;
        break;
      end
      if (!busy_o) held = 0;
      if (hi_o !== h0 || lo_o !== l0) hold = 0;
      @(posedge clk);
      #1;
    end
    if (found) lat = int'(($time - t0 - 1) / 10);
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_busy"}, 64'(held), 64'd1);
    chk({tag, "_hold"}, 64'(hold), 64'd1);
    chk({tag, "_idle"}, 64'(busy_o), 64'd0);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_hi"}, 64'(hi_o), 64'(e[63:32]));
      chk({tag, "_lo"}, 64'(lo_o), 64'(e[31:0]));
      chk({tag, "_dz"}, 64'(div_by_zero_o),
          64'(e[64]));
    end
  endtask

  initial begin
    int pulses;
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    rst_i   = 1'b1;
    start_i = 1'b0;
    op_i    = 2'b00;
    src1_i  = '0;
    src2_i  = '0;
    #3 rst_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_dz", 64'(div_by_zero_o), 64'd0);
    chk("rst_hi", 64'(hi_o), 64'd0);
    chk("rst_lo", 64'(lo_o), 64'd0);
    rst_i = 1'b1;
    @(posedge clk);
    #1;

    start_op(2'b00, 32'hFFFF_FFFD, 32'd5,
             {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF1}, 1);
    wait_done("mult", 33);

    start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
             {1'b0, 32'hFFFF_FFFE, 32'h0000_0001}, 1);
    wait_done("multu", 33);

    start_op(2'b10, 32'hFFFF_FFF9, 32'd2,
             {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1);
    wait_done("div", 33);

    start_op(2'b11, 32'd100, 32'd7,
             {1'b0, 32'd2, 32'd14}, 1);
    wait_done("divu", 33);

    start_op(2'b11, 32'd100, 32'd0,
             {1'b1, 32'h0000_0064, 32'hFFFF_FFFF}, 1);
    wait_done("divu_zero", 1);
    @(posedge clk);
    #1;
    chk("dz_pulse_end", 64'(div_by_zero_o), 64'd0);
    chk("done_pulse_end", 64'(done_o), 64'd0);

    start_op(2'b11, 32'd1000, 32'd9,
             {1'b0, 32'd1, 32'd111}, 1);
    repeat (5) begin @(posedge clk); #1; end
    start_i = 1'b1;
    op_i    = 2'b00;
    src1_i  = 32'd2;
    src2_i  = 32'd3;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    wait_done("busy_ignore", 33);

    start_op(2'b00, 32'h1234, 32'h5678, '0, 0);
    repeat (10) begin @(posedge clk); #1; end
    chk("calc_hold_hi", 64'(hi_o), 64'd1);
    chk("calc_hold_lo", 64'(lo_o), 64'd111);
    chk("calc_busy", 64'(busy_o), 64'd1);
    rst_i = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy_o), 64'd0);
    chk("midrst_hi", 64'(hi_o), 64'd0);
    chk("midrst_lo", 64'(lo_o), 64'd0);
    chk("midrst_done", 64'(done_o), 64'd0);
    @(posedge clk);
    #1;
    rst_i = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done_o) pulses++;
    end
    chk("no_done_after_rst", 64'(pulses), 64'd0);
    chk("idle_after_rst", 64'(busy_o), 64'd0);

    start_op(2'b01, 32'd7, 32'd6,
             {1'b0, 32'd0, 32'd42}, 1);
    wait_done("fresh", 33);

    start_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF,
             {1'b0, 32'd0, 32'h8000_0000}, 1);
    wait_done("div_ovf", 33);

    // issued in the done_o cycle of div_ovf
    start_op(2'b10, 32'hFFFF_FF9C, 32'd7,
             {1'b0, 32'hFFFF_FFFE, 32'hFFFF_FFF2}, 1);
    wait_done("b2b", 33);

    for (int k = 0; k < 10; k++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 5) == 0) rb = '0;
      start_op(rop, ra, rb, ref_md(rop, ra, rb), 1);
      wait_done($sformatf("rnd%0d", k),
                (rop[1] && rb == 0) ? 1 : 33);
    end

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/md_sequencer.md
Name: md_sequencer

Overview:
- Iterative multiply/divide unit and its controller for the pipelined MIPS core.
- Accepts MULT/MULTU/DIV/DIVU operands from the EX stage.
- Runs a shared shift-add / restoring-divide datapath over WIDTH cycles and holds the HI/LO results.
- Drives busy_o so the hazard logic stalls IF/ID/EX while an operation is in flight.

Parameters:
- WIDTH, 32: operand width; HI and LO are each WIDTH bits.

Ports:
- clk_i  input  1  system clock, rising edge.
- rst_i  input  1  asynchronous active-low reset.
- start_i  input  1  request to begin an operation; sampled only in IDLE.
- op_i  input  2  operation select: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- src1_i  input  WIDTH  multiplicand or dividend (rs).
- src2_i  input  WIDTH  multiplier or divisor (rt).
- busy_o  output  1  high while state != IDLE; used as pipeline stall.
- done_o  output  1  one-cycle pulse; hi_o/lo_o are valid from this cycle.
- div_by_zero_o  output  1  pulses together with done_o when a DIV/DIVU had src2_i == 0.
- hi_o  output  WIDTH  product high half, or remainder.
- lo_o  output  WIDTH  product low half, or quotient.

Behaviour:
- Reset (async, rst_i=0):
  - State goes to IDLE; counter is 0.
  - hi_o, lo_o = 0; done_o, div_by_zero_o = 0; busy_o = 0.
  - Reset mid-operation abandons the operation; no done_o is produced.
- States: IDLE, CALC, FIX.
- IDLE:
  - On a rising edge with start_i=1, latch op_i.
  - For signed ops, latch the operand magnitudes and the result signs: product sign = s1^s2; quotient sign = s1^s2; remainder sign = s1.
  - For unsigned ops, operands are taken as-is.
  - Divide by zero (op DIV/DIVU, src2_i=0) goes to FIX with a dz flag set. Otherwise go to CALC with counter = 0.
- CALC: one iteration per cycle, exactly WIDTH cycles; move to FIX when counter == WIDTH-1.
  - Multiply: 2*WIDTH-bit accumulator, shift-add, LSB-first on the multiplier.
  - Divide: restoring algorithm on {remainder, quotient}.
  - Use a WIDTH+1-bit subtract to detect borrow.
- FIX: one cycle.
  - Apply sign correction by two's-complement negation of the product, quotient or remainder as latched.
  - Write hi_o and lo_o, set done_o=1 for one cycle, and return to IDLE.
  - In the dz case: hi_o = dividend (unmodified src1), lo_o = all ones, div_by_zero_o=1.
- Latency, with acceptance edge E0:
  - Normal: results and done_o are registered at edge E0+WIDTH+1, so busy_o is high for WIDTH+1 cycles.
  - Divide by zero: results and done_o are registered at E1, so busy_o is high for 1 cycle.
- done_o and div_by_zero_o are registered and low in every other cycle.
- hi_o and lo_o hold their value until the next FIX; they do not change during CALC.
- start_i while busy_o=1 is ignored. It is not queued, and the latched operands do not change.
- start_i in the same cycle that done_o is high is accepted; back-to-back issue is legal.
- Signed overflow: 0x80000000 / 0xFFFFFFFF (WIDTH=32) gives lo_o=0x80000000, hi_o=0. This falls out of the magnitude path; there is no special case and no flag.
- Widths:
  - Negation is modulo 2^WIDTH for the quotient and remainder, and modulo 2^(2*WIDTH) for the product.
  - The counter is clog2(WIDTH)+1 bits.

Decomposition:
- Shared package md_pkg holds:
  - op encodings MD_MULT, MD_MULTU, MD_DIV, MD_DIVU;
  - the state enum (IDLE, CALC, FIX);
  - the DIV0_LO constant (all ones).
- One sub-module, md_datapath:
  - holds the accumulator and shift registers, the add/subtract step, and the sign fix;
  - is controlled by load, step and fix strobes from the FSM in md_sequencer.

Test Plan:
- MULT signed: src1=0xFFFFFFFD (-3), src2=5, start at E0 → busy_o for 33 cycles, done_o at E0+33, hi_o=0xFFFFFFFF, lo_o=0xFFFFFFF1.
- MULTU: 0xFFFFFFFF × 0xFFFFFFFF → hi_o=0xFFFFFFFE, lo_o=0x00000001, div_by_zero_o=0.
- DIV signed: -7 (0xFFFFFFF9) / 2 → lo_o=0xFFFFFFFD (-3), hi_o=0xFFFFFFFF (-1). DIVU 100/7 → lo_o=14, hi_o=2.
- DIVU 100/0 → busy_o for 1 cycle, done_o and div_by_zero_o at E1, hi_o=0x00000064, lo_o=0xFFFFFFFF.
- Busy and reset:
  - Second start_i with new operands during CALC → ignored; the first result is delivered unchanged.
  - rst_i low mid-CALC → busy_o=0, hi_o=lo_o=0 immediately, no done_o.
  - A fresh start after reset completes correctly.
- Signed overflow and back-to-back:
  - DIV 0x80000000 / 0xFFFFFFFF → lo_o=0x80000000, hi_o=0.
  - start_i held high in the done_o cycle → the next op is accepted and its done_o arrives WIDTH+1 cycles later.
